// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared widths and status packing for the golden nonce path
package miner_pkg;

  localparam int NONCE_W        = 32;
  localparam int RESULT_W       = 96;
  localparam int STATUS_W       = 8;
  localparam int STATUS_OVF_BIT = 7;

  // Count occupies the low bits; everything between count and the ovf bit reads zero.
  function automatic logic [STATUS_W-1:0] make_status(input logic ovf, input logic [6:0] cnt);
    logic [STATUS_W-1:0] s;
    s                 = {1'b0, cnt};
    s[STATUS_OVF_BIT] = ovf;
    return s;
  endfunction

endpackage

// File: rtl/gn_fifo.sv
// rtl/gn_fifo.sv - small synchronous FIFO with combinational head read
module gn_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = NONCE_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push on full is only taken when a pop frees the head slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_queue.sv
// rtl/golden_nonce_queue.sv - queues new golden nonces and hands one per host snapshot
module golden_nonce_queue
  import miner_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NONCE_W-1:0]  golden_nonce,
  input  logic [NONCE_W-1:0]  nonce2,
  input  logic [NONCE_W-1:0]  hash2,
  input  logic                snap,
  output logic [RESULT_W-1:0] out_data,
  output logic [STATUS_W-1:0] out_status,
  output logic                out_strobe
);

  logic [NONCE_W-1:0] last_gn;
  logic [NONCE_W-1:0] head;
  logic [NONCE_W-1:0] head_or_zero;
  logic [AW:0]        count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               overflow;
  logic               ovf;

  // The core holds its last find; only a change to a new non-zero value is a new nonce.
  assign push         = (golden_nonce != '0) && (golden_nonce != last_gn);
  assign pop          = snap && !empty;
  assign overflow     = push && full && !pop;
  assign head_or_zero = empty ? {NONCE_W{1'b0}} : head;

  gn_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (NONCE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (golden_nonce),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gn <= '0;
      ovf     <= 1'b0;
    end else begin
      if (push) begin
        last_gn <= golden_nonce;
      end
      // Set wins over the clear-on-read so a coinciding drop is never hidden.
      if (overflow) begin
        ovf <= 1'b1;
      end else if (snap) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data   <= '0;
      out_status <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= snap;
      if (snap) begin
        out_data   <= {hash2, nonce2, head_or_zero};
        out_status <= make_status(ovf, 7'(count));
      end
    end
  end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// tb/tb_golden_nonce_queue.sv - scoreboard bench for golden_nonce_queue
module tb_golden_nonce_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [31:0] gn;
  logic [31:0] nonce2;
  logic [31:0] hash2;
  logic        snap;
  logic [95:0] out_data;
  logic [7:0]  out_status;
  logic        out_strobe;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_fifo[$];
  logic [31:0] m_last;
  logic        m_ovf;
  logic [95:0] exp_data_q[$];
  logic [7:0]  exp_stat_q[$];

  golden_nonce_queue #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .golden_nonce (gn),
    .nonce2       (nonce2),
    .hash2        (hash2),
    .snap         (snap),
    .out_data     (out_data),
    .out_status   (out_status),
    .out_strobe   (out_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the current inputs to the model, then advance one edge (ends at posedge+1).
  task automatic step();
    bit push, pop, full;
    push = (gn != 0) && (gn != m_last);
    full = (m_fifo.size() == DEPTH);
    pop  = snap && (m_fifo.size() > 0);
    if (snap) begin
      exp_data_q.push_back({hash2, nonce2, (m_fifo.size() > 0) ? m_fifo[0] : 32'h0});
      exp_stat_q.push_back({m_ovf, 3'b000, 4'(m_fifo.size())});
    end
    if (push && full && !pop) m_ovf = 1'b1;
    else if (snap) m_ovf = 1'b0;
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      m_last = gn;
      if (!full || pop) m_fifo.push_back(gn);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    exp_data_q.delete();
    exp_stat_q.delete();
  endtask

  task automatic do_reset();
    gn = '0; snap = 1'b0; reset = 1'b0;
    #3;
    model_clear();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_data !== 96'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_status !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", out_status); end
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", out_strobe); end
  endtask

  task automatic test_single();
    logic [95:0] ed; logic [7:0] es;
    do_reset();
    gn = 32'h1234_5678;
    repeat (10) step();
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_strobe !== 1'b1) begin errors++; $display("FAIL single_strobe got %b exp 1", out_strobe); end
    checks++; if (out_data !== ed) begin errors++; $display("FAIL single_data got %h exp %h", out_data, ed); end
    checks++; if (out_data[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL single_nonce got %h exp 12345678", out_data[31:0]); end
    checks++; if (out_status !== 8'h01 || out_status !== es) begin errors++; $display("FAIL single_status got %h exp 01", out_status); end
    step();
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL single_strobe_drop got %b exp 0", out_strobe); end
  endtask

  task automatic test_sequence();
    logic [95:0] ed; logic [7:0] es;
    logic [31:0] a, b;
    logic [31:0] exp_n[4];
    logic [7:0]  exp_c[4];
    a = 32'hA5A5_0001; b = 32'hB0B0_0002;
    exp_n = '{a, b, a, 32'h0};
    exp_c = '{8'h03, 8'h02, 8'h01, 8'h00};
    do_reset();
    gn = a; repeat (3) step();
    gn = b; repeat (3) step();
    gn = a; repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      snap = 1'b1; step(); snap = 1'b0;
      ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
      checks++; if (out_data[31:0] !== exp_n[i] || out_data !== ed) begin errors++; $display("FAIL seq_nonce%0d got %h exp %h", i, out_data[31:0], exp_n[i]); end
      checks++; if (out_status !== exp_c[i] || out_status !== es) begin errors++; $display("FAIL seq_status%0d got %h exp %h", i, out_status, exp_c[i]); end
      step();
    end
  endtask

  task automatic test_overflow();
    logic [95:0] ed; logic [7:0] es;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      gn = 32'h1000_0001 + i;
      step();
    end
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_status !== 8'h88 || out_status !== es) begin errors++; $display("FAIL ovf_status got %h exp 88", out_status); end
    checks++; if (out_data[31:0] !== 32'h1000_0001 || out_data !== ed) begin errors++; $display("FAIL ovf_nonce got %h exp 10000001", out_data[31:0]); end
    step();
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_status !== 8'h07 || out_status !== es) begin errors++; $display("FAIL ovf_clear_status got %h exp 07", out_status); end
    checks++; if (out_data[31:0] !== 32'h1000_0002 || out_data !== ed) begin errors++; $display("FAIL ovf_clear_nonce got %h exp 10000002", out_data[31:0]); end
  endtask

  task automatic test_full_push_pop();
    logic [95:0] ed; logic [7:0] es;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      gn = 32'h2000_0001 + i;
      step();
    end
    gn = 32'h2000_00FF; snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_status !== 8'h08 || out_status !== es) begin errors++; $display("FAIL full_status got %h exp 08", out_status); end
    checks++; if (out_data[31:0] !== 32'h2000_0001 || out_data !== ed) begin errors++; $display("FAIL full_nonce got %h exp 20000001", out_data[31:0]); end
    step();
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_status !== 8'h08 || out_status !== es) begin errors++; $display("FAIL full_keep_status got %h exp 08", out_status); end
    checks++; if (out_data[31:0] !== 32'h2000_0002 || out_data !== ed) begin errors++; $display("FAIL full_keep_nonce got %h exp 20000002", out_data[31:0]); end
  endtask

  task automatic test_mid_reset();
    logic [95:0] ed; logic [7:0] es;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      gn = 32'h3000_0001 + i;
      step();
    end
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_status !== 8'h03 || out_status !== es) begin errors++; $display("FAIL pre_reset_status got %h exp 03", out_status); end
    #3 reset = 1'b0; gn = '0;
    #1;
    model_clear();
    checks++; if (out_data !== 96'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", out_data); end
    checks++; if (out_status !== 8'h00) begin errors++; $display("FAIL midrst_status got %h exp 00", out_status); end
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL midrst_strobe got %b exp 0", out_strobe); end
    #2 reset = 1'b1;
    step();
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_status !== 8'h00 || out_status !== es) begin errors++; $display("FAIL postrst_status got %h exp 00", out_status); end
    checks++; if (out_data[31:0] !== 32'h0 || out_data !== ed) begin errors++; $display("FAIL postrst_nonce got %h exp 0", out_data[31:0]); end
    gn = 32'h3000_0003; step(); step();
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_data[31:0] !== 32'h3000_0003 || out_data !== ed) begin errors++; $display("FAIL reaccept_nonce got %h exp 30000003", out_data[31:0]); end
    checks++; if (out_status !== 8'h01 || out_status !== es) begin errors++; $display("FAIL reaccept_status got %h exp 01", out_status); end
  endtask

  task automatic test_empty_bypass();
    logic [95:0] ed; logic [7:0] es;
    do_reset();
    gn = 32'h4000_0001; snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_data[31:0] !== 32'h0 || out_data !== ed) begin errors++; $display("FAIL bypass_nonce got %h exp 0", out_data[31:0]); end
    checks++; if (out_status !== 8'h00 || out_status !== es) begin errors++; $display("FAIL bypass_status got %h exp 00", out_status); end
    step();
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_data[31:0] !== 32'h4000_0001 || out_data !== ed) begin errors++; $display("FAIL bypass_next_nonce got %h exp 40000001", out_data[31:0]); end
    checks++; if (out_status !== 8'h01 || out_status !== es) begin errors++; $display("FAIL bypass_next_status got %h exp 01", out_status); end
  endtask

  task automatic test_debug_words();
    logic [95:0] ed; logic [7:0] es;
    do_reset();
    hash2 = 32'hDEAD_BEEF; nonce2 = 32'h0000_0042;
    snap = 1'b1; step(); snap = 1'b0;
    ed = exp_data_q.pop_front(); es = exp_stat_q.pop_front();
    checks++; if (out_data !== 96'hDEADBEEF_00000042_00000000 || out_data !== ed) begin errors++; $display("FAIL debug_data got %h exp DEADBEEF0000004200000000", out_data); end
    checks++; if (out_status !== 8'h00 || out_status !== es) begin errors++; $display("FAIL debug_status got %h exp 00", out_status); end
    hash2 = '0; nonce2 = '0;
  endtask

  initial begin
    reset = 1'b0; gn = '0; nonce2 = '0; hash2 = '0; snap = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_sequence();
    test_overflow();
    test_full_push_pop();
    test_mid_reset();
    test_empty_bypass();
    test_debug_words();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
